// File: rtl/serial_cmp_sequencer_pkg.sv
// Shared types and defaults for the bit-serial equality sequencer.
package serial_cmp_pkg;

  localparam int unsigned DEF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_cmp_sequencer_if.sv
// Start/busy/done handshake and operand/result bus of the serial compare sequencer.
interface serial_cmp_sequencer_if #(
  parameter int unsigned W = 8
);
  localparam int unsigned CNT_W = $clog2(W);

  logic             start;
  logic             abort;
  logic [W-1:0]     a_in;
  logic [W-1:0]     b_in;
  logic             busy;
  logic             done;
  logic             match;
  logic [CNT_W-1:0] first_diff;

  modport master (
    output start, abort, a_in, b_in,
    input  busy, done, match, first_diff
  );

  modport slave (
    input  start, abort, a_in, b_in,
    output busy, done, match, first_diff
  );
endinterface

// File: rtl/serial_cmp_sequencer_bit_eq_stage.sv
// Registered one-bit equality stage of the serial compare datapath.
module bit_eq_stage (
  input  logic clk,
  input  logic rstn,
  input  logic x1,
  input  logic x2,
  output logic eq_q
);
  logic r_eq;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_eq <= 1'b0;
    else       r_eq <= (x1 == x2);
  end

  assign eq_q = r_eq;
endmodule

// File: rtl/serial_cmp_sequencer.sv
// Shifts two captured words LSB-first through the equality stage and reports
// whole-word match plus the lowest mismatching bit index.
module serial_cmp_sequencer
  import serial_cmp_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic                   clk,
  input  logic                   rstn,
  serial_cmp_sequencer_if.slave  bus
);
  localparam int unsigned    CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_a_sr, r_b_sr;
  logic [CNT_W-1:0] r_cnt, r_sidx, r_fd_acc, r_first_diff;
  logic             r_seen, r_match;
  logic             w_eq_q, w_accept, w_sample;

  bit_eq_stage u_eq (
    .clk  (clk),
    .rstn (rstn),
    .x1   (r_a_sr[0]),
    .x2   (r_b_sr[0]),
    .eq_q (w_eq_q)
  );

  assign w_accept = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);
  // eq_q trails the presented bit by one edge, so nothing is valid on the first SHIFT cycle
  assign w_sample = (r_state == ST_SHIFT) && (r_cnt != '0);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (bus.abort)          w_state_nxt = ST_IDLE;
        else if (r_cnt == LAST) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = bus.abort ? ST_IDLE : ST_DONE;
      ST_DONE:  w_state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_sr       <= '0;
      r_b_sr       <= '0;
      r_cnt        <= '0;
      r_sidx       <= '0;
      r_fd_acc     <= '0;
      r_seen       <= 1'b0;
      r_match      <= 1'b0;
      r_first_diff <= '0;
    end else if (w_accept) begin
      r_a_sr   <= bus.a_in;
      r_b_sr   <= bus.b_in;
      r_cnt    <= '0;
      r_sidx   <= '0;
      r_fd_acc <= '0;
      r_seen   <= 1'b0;
    end else if (r_state == ST_SHIFT && !bus.abort) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_cnt  <= r_cnt + 1'b1;
      r_sidx <= r_cnt;
      if (w_sample && !w_eq_q && !r_seen) begin
        r_seen   <= 1'b1;
        r_fd_acc <= r_sidx;
      end
    end else if (r_state == ST_DRAIN && !bus.abort) begin
      // results publish only on completion so an aborted job leaves the previous ones intact
      r_match      <= r_seen ? 1'b0 : w_eq_q;
      r_first_diff <= r_seen ? r_fd_acc : (w_eq_q ? '0 : r_sidx);
    end
  end

  assign bus.busy       = (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.match      = r_match;
  assign bus.first_diff = r_first_diff;
endmodule
